// File: rtl/gnrl_skid_buf.sv
// Two-entry valid/ready skid buffer: data, valid and upstream ready all come from flops.
// Optional simulation X/stability checks are compiled in with GNRL_SKID_XCHK_EN.
module gnrl_skid_buf #(
  parameter int DW      = 32,
  parameter bit DAT_RST = 1'b0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_vld,
  output logic          i_rdy,
  input  logic [DW-1:0] i_dat,
  output logic          o_vld,
  input  logic          o_rdy,
  output logic [DW-1:0] o_dat,
  output logic [1:0]    o_cnt
);

  // Handshake: a beat moves when vld and rdy are both high at a posedge; o_vld/o_dat
  // hold until accepted, and the source keeps i_vld/i_dat stable while i_rdy is low.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t        state;
  logic [DW-1:0] skid_dat;

  // The state encoding equals the occupancy, so the count is a register output.
  assign o_cnt = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= EMPTY;
      o_vld <= 1'b0;
      i_rdy <= 1'b1;
      if (DAT_RST) begin
        o_dat    <= '0;
        skid_dat <= '0;
      end
    end else begin
      case (state)
        EMPTY: begin
          if (i_vld) begin
            o_dat <= i_dat;
            o_vld <= 1'b1;
            state <= ONE;
          end
        end
        ONE: begin
          if (i_vld && o_rdy) begin
            o_dat <= i_dat;
          end else if (i_vld) begin
            skid_dat <= i_dat;
            i_rdy    <= 1'b0;
            state    <= FULL;
          end else if (o_rdy) begin
            o_vld <= 1'b0;
            state <= EMPTY;
          end
        end
        FULL: begin
          // Upstream is stalled here; draining skid into main keeps the stream bubble-free.
          if (o_rdy) begin
            o_dat <= skid_dat;
            i_rdy <= 1'b1;
            state <= ONE;
          end
        end
        default: begin
          state <= EMPTY;
          o_vld <= 1'b0;
          i_rdy <= 1'b1;
        end
      endcase
    end
  end

`ifdef GNRL_SKID_XCHK_EN
  a_dat_known: assert property (@(posedge clk) disable iff (rst)
    (o_vld === 1'b1) |-> !$isunknown(o_dat))
    else $fatal(1, "gnrl_skid_buf: X on o_dat while o_vld");

  a_ctl_known: assert property (@(posedge clk) disable iff (rst)
    !$isunknown({o_vld, i_rdy}))
    else $fatal(1, "gnrl_skid_buf: X on o_vld/i_rdy");

  a_dat_stable: assert property (@(posedge clk) disable iff (rst)
    (o_vld && !o_rdy) |=> $stable(o_dat))
    else $fatal(1, "gnrl_skid_buf: o_dat changed while stalled");
`else
  // Checks disabled: the datapath above is unchanged.
`endif

endmodule

// File: tb/tb_gnrl_skid_buf.sv
// Directed and random tests for gnrl_skid_buf (DAT_RST=1 build).
module tb_gnrl_skid_buf;

  localparam int DW = 32;

  logic          clk;
  logic          rst;
  logic          i_vld;
  logic          i_rdy;
  logic [DW-1:0] i_dat;
  logic          o_vld;
  logic          o_rdy;
  logic [DW-1:0] o_dat;
  logic [1:0]    o_cnt;

  int total = 0;
  int bad   = 0;
  logic [DW-1:0] exp_q[$];

  gnrl_skid_buf #(.DW(DW), .DAT_RST(1'b1)) dut (
    .clk   (clk),
    .rst   (rst),
    .i_vld (i_vld),
    .i_rdy (i_rdy),
    .i_dat (i_dat),
    .o_vld (o_vld),
    .o_rdy (o_rdy),
    .o_dat (o_dat),
    .o_cnt (o_cnt)
  );

  // clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive and sample 1ns after the active edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; i_vld = 1'b1; i_dat = 32'hDEAD_BEEF; o_rdy = 1'b0;
    tick(); tick();
    total++; if (o_vld !== 1'b0) begin bad++; $display("FAIL reset_o_vld got=%b exp=0", o_vld); end
    total++; if (i_rdy !== 1'b1) begin bad++; $display("FAIL reset_i_rdy got=%b exp=1", i_rdy); end
    total++; if (o_cnt !== 2'd0) begin bad++; $display("FAIL reset_o_cnt got=%0d exp=0", o_cnt); end
    total++; if (o_dat !== 32'h0) begin bad++; $display("FAIL reset_o_dat got=%h exp=0", o_dat); end
    rst = 1'b0; i_vld = 1'b0;
  endtask

  task automatic test_streaming();
    o_rdy = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      i_vld = 1'b1; i_dat = DW'(k);
      tick();
      total++; if (o_vld !== 1'b1 || o_dat !== DW'(k)) begin
        bad++; $display("FAIL stream_beat%0d got vld=%b dat=%h exp vld=1 dat=%h", k, o_vld, o_dat, DW'(k));
      end
      total++; if (o_cnt !== 2'd1 || i_rdy !== 1'b1) begin
        bad++; $display("FAIL stream_cnt%0d got cnt=%0d rdy=%b exp cnt=1 rdy=1", k, o_cnt, i_rdy);
      end
    end
    i_vld = 1'b0;
    tick();
    total++; if (o_vld !== 1'b0 || o_cnt !== 2'd0) begin
      bad++; $display("FAIL stream_drain got vld=%b cnt=%0d exp vld=0 cnt=0", o_vld, o_cnt);
    end
  endtask

  task automatic test_backpressure();
    o_rdy = 1'b0;
    i_vld = 1'b1; i_dat = 32'hA;
    tick();
    total++; if (o_dat !== 32'hA || o_cnt !== 2'd1) begin
      bad++; $display("FAIL bp_first got dat=%h cnt=%0d exp dat=a cnt=1", o_dat, o_cnt);
    end
    i_dat = 32'hB;
    tick();
    total++; if (o_cnt !== 2'd2 || i_rdy !== 1'b0 || o_dat !== 32'hA) begin
      bad++; $display("FAIL bp_full got cnt=%0d rdy=%b dat=%h exp cnt=2 rdy=0 dat=a", o_cnt, i_rdy, o_dat);
    end
    i_dat = 32'hC;
    tick();
    total++; if (o_cnt !== 2'd2 || i_rdy !== 1'b0 || o_dat !== 32'hA || o_vld !== 1'b1) begin
      bad++; $display("FAIL bp_hold got cnt=%0d rdy=%b dat=%h vld=%b exp cnt=2 rdy=0 dat=a vld=1", o_cnt, i_rdy, o_dat, o_vld);
    end
    o_rdy = 1'b1;
    tick();
    total++; if (o_vld !== 1'b1 || o_dat !== 32'hB || o_cnt !== 2'd1 || i_rdy !== 1'b1) begin
      bad++; $display("FAIL bp_drain_b got vld=%b dat=%h cnt=%0d rdy=%b exp vld=1 dat=b cnt=1 rdy=1", o_vld, o_dat, o_cnt, i_rdy);
    end
    tick();
    total++; if (o_vld !== 1'b1 || o_dat !== 32'hC || o_cnt !== 2'd1) begin
      bad++; $display("FAIL bp_drain_c got vld=%b dat=%h cnt=%0d exp vld=1 dat=c cnt=1", o_vld, o_dat, o_cnt);
    end
    i_vld = 1'b0;
    tick();
    total++; if (o_vld !== 1'b0 || o_cnt !== 2'd0) begin
      bad++; $display("FAIL bp_empty got vld=%b cnt=%0d exp vld=0 cnt=0", o_vld, o_cnt);
    end
  endtask

  task automatic test_simultaneous();
    o_rdy = 1'b0; i_vld = 1'b1; i_dat = 32'h5;
    tick();
    total++; if (o_dat !== 32'h5 || o_cnt !== 2'd1) begin
      bad++; $display("FAIL simul_load got dat=%h cnt=%0d exp dat=5 cnt=1", o_dat, o_cnt);
    end
    i_dat = 32'h6; o_rdy = 1'b1;
    tick();
    total++; if (o_dat !== 32'h6 || o_cnt !== 2'd1 || i_rdy !== 1'b1 || o_vld !== 1'b1) begin
      bad++; $display("FAIL simul_swap got dat=%h cnt=%0d rdy=%b vld=%b exp dat=6 cnt=1 rdy=1 vld=1", o_dat, o_cnt, i_rdy, o_vld);
    end
    i_vld = 1'b0;
    tick();
    total++; if (o_cnt !== 2'd0) begin bad++; $display("FAIL simul_empty got cnt=%0d exp=0", o_cnt); end
  endtask

  task automatic test_mid_reset();
    o_rdy = 1'b0; i_vld = 1'b1; i_dat = 32'h7;
    tick();
    i_dat = 32'h8;
    tick();
    total++; if (o_cnt !== 2'd2) begin bad++; $display("FAIL midrst_full got cnt=%0d exp=2", o_cnt); end
    i_vld = 1'b0; rst = 1'b1; o_rdy = 1'b1;
    tick();
    total++; if (o_vld !== 1'b0 || o_cnt !== 2'd0 || i_rdy !== 1'b1 || o_dat !== 32'h0) begin
      bad++; $display("FAIL midrst_flush got vld=%b cnt=%0d rdy=%b dat=%h exp vld=0 cnt=0 rdy=1 dat=0", o_vld, o_cnt, i_rdy, o_dat);
    end
    rst = 1'b0;
    tick();
    total++; if (o_vld !== 1'b0) begin bad++; $display("FAIL midrst_nostale got vld=%b exp=0", o_vld); end
    i_vld = 1'b1; i_dat = 32'h9;
    tick();
    total++; if (o_vld !== 1'b1 || o_dat !== 32'h9) begin
      bad++; $display("FAIL midrst_new got vld=%b dat=%h exp vld=1 dat=9", o_vld, o_dat);
    end
    i_vld = 1'b0;
    tick();
    total++; if (o_cnt !== 2'd0) begin bad++; $display("FAIL midrst_empty got cnt=%0d exp=0", o_cnt); end
  endtask

  // Scoreboard: beats pushed on input handshake, popped and compared on output handshake.
  task automatic test_random();
    logic pending;
    logic [DW-1:0] exp;
    pending = 1'b0;
    exp_q.delete();
    for (int c = 0; c < 3000; c++) begin
      if (!pending) begin
        i_vld = c < 2990 ? 1'($urandom_range(0, 1)) : 1'b0;
        i_dat = $urandom();
      end
      o_rdy = 1'($urandom_range(0, 3) != 0 || c >= 2990);
      if (o_vld && o_rdy) begin
        if (exp_q.size() == 0) begin
          total++; bad++; $display("FAIL rand_dup cycle=%0d got dat=%h exp none", c, o_dat);
        end else begin
          exp = exp_q.pop_front();
          total++; if (o_dat !== exp) begin
            bad++; $display("FAIL rand_data cycle=%0d got=%h exp=%h", c, o_dat, exp);
          end
        end
      end
      if (i_vld && i_rdy) exp_q.push_back(i_dat);
      pending = i_vld && !i_rdy;
      tick();
      total++; if (o_cnt !== 2'(exp_q.size()) || o_vld !== (exp_q.size() != 0) || i_rdy !== (exp_q.size() < 2)) begin
        bad++; $display("FAIL rand_occ cycle=%0d got cnt=%0d vld=%b rdy=%b exp cnt=%0d", c, o_cnt, o_vld, i_rdy, exp_q.size());
      end
    end
    total++; if (exp_q.size() != 0) begin
      bad++; $display("FAIL rand_loss got left=%0d exp=0", exp_q.size());
    end
    i_vld = 1'b0;
  endtask

  initial begin
    rst = 1'b1; i_vld = 1'b0; i_dat = '0; o_rdy = 1'b0;
    test_reset();
    test_streaming();
    test_backpressure();
    test_simultaneous();
    test_mid_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
